// File: rtl/bcd_display_scanner_pkg.sv
// Shared definitions for the BCD display scanner: 7-segment codes ({g,f,e,d,c,b,a}, active-high)
// and a nibble range helper.
package bcd_display_scanner_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic nibble_invalid(input logic [3:0] nib);
    return (nib > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_seg7.sv
// Combinational BCD to 7-segment decoder; any nibble outside 0..9 renders as a dash.
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Nibble to segment pattern lookup
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes DIGITS captured BCD nibbles onto one 7-segment bus with a one-hot digit
// enable, leading-zero blanking and an out-of-range flag. All outputs are registered.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  err
);

  // A one-bit counter is kept for PRESCALE=1 so the width never collapses to zero.
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                err_q,    err_d;
  logic [6:0]          seg_q,    seg_d;
  logic [DIGITS-1:0]   an_q,     an_d;
  logic                fd_q,     fd_d;

  logic [3:0] cur_nib_s;
  logic       cur_zero_s;
  logic       zero_above_s;
  logic       inv_any_s;
  logic [6:0] dec_seg_s;

  bcd_to_seg7 u_dec (
    .bcd_i (cur_nib_s),
    .seg_o (dec_seg_s)
  );

  // Prescaler and digit index sequencing
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    fd_d  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
        fd_d  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Shadow capture and range flag, evaluated on the incoming value
  always_comb begin
    inv_any_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      inv_any_s = inv_any_s | nibble_invalid(bcd_in[4*i +: 4]);
    end
    if (load) begin
      shadow_d = bcd_in;
      err_d    = inv_any_s;
    end else begin
      shadow_d = shadow_q;
      err_d    = err_q;
    end
  end

  // Select the active nibble; scanning from the top tracks whether it and everything above is zero
  always_comb begin
    cur_nib_s    = 4'h0;
    cur_zero_s   = 1'b0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (shadow_q[4*i +: 4] == 4'h0);
      cur_nib_s    = (idx_q == IDX_W'(i)) ? shadow_q[4*i +: 4] : cur_nib_s;
      cur_zero_s   = (idx_q == IDX_W'(i)) ? zero_above_s       : cur_zero_s;
    end
  end

  // Output pattern and digit enable for the current index
  always_comb begin
    if (blank_lz && (idx_q != {IDX_W{1'b0}}) && cur_zero_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg_s;
    end
    an_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      shadow_q <= {(4*DIGITS){1'b0}};
      err_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      an_q     <= {DIGITS{1'b0}};
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (DIGITS=4, PRESCALE=4, 20ns clock).
module tb_bcd_display_scanner;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];

  localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_display_scanner #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .err        (err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every time a new digit is presented, compare against the scoreboard head
  initial begin
    logic [3:0]  prev_an;
    logic [10:0] e;
    prev_an = 4'b0000;
    forever begin
      @(negedge clk);
      if (!reset && an !== prev_an && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an, seg} !== e) begin
          errors++;
          $display("FAIL scan actual an=%b seg=%h expected an=%b seg=%h",
                   an, seg, e[10:7], e[6:0]);
        end
      end
      prev_an = an;
    end
  end

  task automatic do_load(input logic [15:0] v, input logic bl, input logic exp_err);
    @(negedge clk);
    bcd_in   = v;
    load     = 1'b1;
    blank_lz = bl;
    @(negedge clk);
    load = 1'b0;
    chk("err_after_load", {31'd0, err}, {31'd0, exp_err});
  endtask

  // Waits for a frame boundary, then queues the four digits the next frame must show
  task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    if (!found) begin
      chk("frame_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({4'b0001, s0});
      exp_q.push_back({4'b0010, s1});
      exp_q.push_back({4'b0100, s2});
      exp_q.push_back({4'b1000, s3});
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() > 0) begin
        chk("scan_drain_timeout", exp_q.size(), 32'd0);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    int rises, highs, last_rise, cyc;
    logic prev_fd;
    logic [3:0] hist [40];

    // 1: power-on reset and scan stepping
    reset = 1'b1;
    #45;
    chk("reset_seg", {25'd0, seg}, 32'h00);
    chk("reset_an", {28'd0, an}, 32'h0);
    chk("reset_err", {31'd0, err}, 32'h0);
    chk("reset_fd", {31'd0, frame_done}, 32'h0);
    #5 reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("an_step", {28'd0, an}, 32'd1 << (k / 4));
      if (k == 0) chk("seg_after_reset", {25'd0, seg}, 32'h3F);
    end

    // 2: plain decode, no blanking
    do_load(16'h1209, 1'b0, 1'b0);
    run_frame(7'h6F, 7'h3F, 7'h5B, 7'h06);

    // 3: leading-zero blanking
    do_load(16'h0042, 1'b1, 1'b0);
    run_frame(7'h5B, 7'h66, 7'h00, 7'h00);
    do_load(16'h0000, 1'b1, 1'b0);
    run_frame(7'h3F, 7'h00, 7'h00, 7'h00);

    // 4: invalid nibble renders dash and raises err
    do_load(16'h00A3, 1'b1, 1'b1);
    run_frame(7'h4F, 7'h40, 7'h00, 7'h00);
    do_load(16'h0003, 1'b1, 1'b0);
    run_frame(7'h4F, 7'h00, 7'h00, 7'h00);

    // 1b: mid-scan asynchronous reset with err set
    do_load(16'h00A3, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #5 reset = 1'b1;
    #1;
    chk("mid_reset_seg", {25'd0, seg}, 32'h00);
    chk("mid_reset_an", {28'd0, an}, 32'h0);
    chk("mid_reset_err", {31'd0, err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("restart_an", {28'd0, an}, (k < 4) ? 32'd1 : 32'd2);
      if (k == 0) chk("restart_seg", {25'd0, seg}, 32'h3F);
    end

    // 5: frame_done cadence over 64 cycles
    rises = 0; highs = 0; last_rise = -1; prev_fd = 1'b0;
    for (cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      if (frame_done) highs++;
      if (frame_done && !prev_fd) begin
        if (last_rise >= 0) chk("fd_spacing", cyc - last_rise, 32'd16);
        last_rise = cyc;
        rises++;
      end
      prev_fd = frame_done;
    end
    chk("fd_pulses", rises, 32'd4);
    chk("fd_width", highs, 32'd4);

    // 6: continuous load from a decade counter
    blank_lz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("an_onehot", {31'd0, $onehot(an)}, 32'd1);
      if (i >= 2 && an == 4'b0001) chk("track_seg", {25'd0, seg}, {25'd0, SEGTAB[hist[i-2]]});
      hist[i] = 4'(i % 10);
      bcd_in  = {8'h00, 4'((i / 10) % 10), hist[i]};
      load    = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
